// File: rtl/karatsuba_pkg.sv
// Shared definitions for the Karatsuba operand-splitting stages.
// Optional sum outputs are enabled with the KSPLIT_SUM_EN macro.
package karatsuba_pkg;

    localparam int KSPLIT_WIDTH = 32;
    localparam int KSPLIT_HALF  = KSPLIT_WIDTH / 2;

    // Result record at the default width; stages built at other widths use
    // the same field order so payloads stay interchangeable.
    typedef struct packed {
`ifdef KSPLIT_SUM_EN
        logic [KSPLIT_HALF:0]   xs;
        logic [KSPLIT_HALF:0]   ys;
`endif
        logic [KSPLIT_HALF-1:0] xl;
        logic [KSPLIT_HALF-1:0] xr;
        logic [KSPLIT_HALF-1:0] yl;
        logic [KSPLIT_HALF-1:0] yr;
    } ksplit_rec_t;

    function automatic int rec_bits(input int half);
`ifdef KSPLIT_SUM_EN
        return 4 * half + 2 * (half + 1);
`else
        return 4 * half;
`endif
    endfunction

endpackage

// File: rtl/karatsuba_skid.sv
// Two-entry valid/ready buffer: an output register backed by one skid register.
// in_ready is registered, so there is no combinational path from out_ready.
module karatsuba_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         accept;

    assign accept = in_valid && in_ready;

    // NOTE: payload registers are reset too, so every output reads 0 during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // Output slot frees this edge; the skid entry is older than any new pair.
            in_ready <= 1'b1;
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end else begin
            in_ready <= !skid_valid;
        end
    end

endmodule

// File: rtl/karatsuba_splitter.sv
// Splits operand pairs into upper/lower halves behind a two-entry skid buffer.
// Define KSPLIT_SUM_EN to add the registered half-sums xs = xl+xr, ys = yl+yr.
module karatsuba_splitter
    import karatsuba_pkg::*;
#(
    parameter int WIDTH = KSPLIT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] xl,
    output logic [WIDTH/2-1:0] xr,
    output logic [WIDTH/2-1:0] yl,
    output logic [WIDTH/2-1:0] yr,
`ifdef KSPLIT_SUM_EN
    output logic [WIDTH/2:0]   xs,
    output logic [WIDTH/2:0]   ys,
`endif
    output logic [15:0]        op_count
);

    localparam int HALF  = WIDTH / 2;
    localparam int REC_W = rec_bits(HALF);

    typedef struct packed {
`ifdef KSPLIT_SUM_EN
        logic [HALF:0]   xs;
        logic [HALF:0]   ys;
`endif
        logic [HALF-1:0] xl;
        logic [HALF-1:0] xr;
        logic [HALF-1:0] yl;
        logic [HALF-1:0] yr;
    } rec_t;

    rec_t             in_rec;
    rec_t             out_rec;
    logic [REC_W-1:0] out_bits;

    always_comb begin
        in_rec.xl = x[WIDTH-1:HALF];
        in_rec.xr = x[HALF-1:0];
        in_rec.yl = y[WIDTH-1:HALF];
        in_rec.yr = y[HALF-1:0];
`ifdef KSPLIT_SUM_EN
        // Zero-extend before adding so the carry lands in the extra bit.
        in_rec.xs = {1'b0, x[WIDTH-1:HALF]} + {1'b0, x[HALF-1:0]};
        in_rec.ys = {1'b0, y[WIDTH-1:HALF]} + {1'b0, y[HALF-1:0]};
`endif
    end

    karatsuba_skid #(.W(REC_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_rec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_bits)
    );

    assign out_rec = out_bits;
    assign xl      = out_rec.xl;
    assign xr      = out_rec.xr;
    assign yl      = out_rec.yl;
    assign yr      = out_rec.yr;
`ifdef KSPLIT_SUM_EN
    assign xs      = out_rec.xs;
    assign ys      = out_rec.ys;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_karatsuba_splitter.sv
// Directed and random checks of karatsuba_splitter at WIDTH=32 and WIDTH=8.
// Sum outputs are checked only when KSPLIT_SUM_EN is defined.
module tb_karatsuba_splitter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        in_ready, out_valid;
    logic [15:0] xl, xr, yl, yr, op_count;
    logic [16:0] xs, ys;

    logic        in_valid8 = 1'b0;
    logic        out_ready8 = 1'b1;
    logic [7:0]  x8 = '0;
    logic [7:0]  y8 = '0;
    logic        in_ready8, out_valid8;
    logic [3:0]  xl8, xr8, yl8, yr8;
    logic [4:0]  xs8, ys8;
    logic [15:0] op_count8;

    always #5 clk = ~clk;

    karatsuba_splitter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .xl(xl), .xr(xr), .yl(yl), .yr(yr),
`ifdef KSPLIT_SUM_EN
        .xs(xs), .ys(ys),
`endif
        .op_count(op_count)
    );

    karatsuba_splitter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .x(x8), .y(y8), .out_valid(out_valid8), .out_ready(out_ready8),
        .xl(xl8), .xr(xr8), .yl(yl8), .yr(yr8),
`ifdef KSPLIT_SUM_EN
        .xs(xs8), .ys(ys8),
`endif
        .op_count(op_count8)
    );

`ifndef KSPLIT_SUM_EN
    assign xs  = '0;
    assign ys  = '0;
    assign xs8 = '0;
    assign ys8 = '0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] x, y;
        logic [15:0] xl, xr, yl, yr;
        logic [16:0] xs, ys;
    } vec_t;

    typedef struct {
        logic [31:0] x, y;
    } pair_t;

    vec_t  vecs[5];
    pair_t q[$];

    initial begin
        vecs[0] = '{32'hABCD1234, 32'h0000FFFF, 16'hABCD, 16'h1234, 16'h0000, 16'hFFFF, 17'h0BE01, 17'h0FFFF};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 17'h1FFFE, 17'h1FFFE};
        vecs[2] = '{32'h00000000, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 17'h00000, 17'h00000};
        vecs[3] = '{32'h80000001, 32'h7FFF8000, 16'h8000, 16'h0001, 16'h7FFF, 16'h8000, 17'h08001, 17'h0FFFF};
        vecs[4] = '{32'h12345678, 32'h9ABCDEF0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 17'h068AC, 17'h179AC};

        // Reset state and first in_ready after release
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_xl", xl, 0);
        check("rst_op_count", op_count, 0);
        #6 rst = 1'b1;
        #1 check("pre_edge_in_ready", in_ready, 0);
        tick();
        check("post_edge_in_ready", in_ready, 1);

        // Back-to-back table vectors, one result per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x = vecs[i].x;
            y = vecs[i].y;
            in_valid = 1'b1;
            tick();
            check($sformatf("v%0d_in_ready", i), in_ready, 1);
            check($sformatf("v%0d_out_valid", i), out_valid, 1);
            check($sformatf("v%0d_xl", i), xl, vecs[i].xl);
            check($sformatf("v%0d_xr", i), xr, vecs[i].xr);
            check($sformatf("v%0d_yl", i), yl, vecs[i].yl);
            check($sformatf("v%0d_yr", i), yr, vecs[i].yr);
`ifdef KSPLIT_SUM_EN
            check($sformatf("v%0d_xs", i), xs, vecs[i].xs);
            check($sformatf("v%0d_ys", i), ys, vecs[i].ys);
`endif
        end
        in_valid = 1'b0;
        tick();
        check("table_drained", out_valid, 0);
        check("table_op_count", op_count, 5);

        // WIDTH=8 instance: 4-bit halves, 5-bit sums
        x8 = 8'hF7; y8 = 8'h9C; in_valid8 = 1'b1;
        tick();
        check("w8a_valid", out_valid8, 1);
        check("w8a_halves", {xl8, xr8, yl8, yr8}, 16'hF79C);
`ifdef KSPLIT_SUM_EN
        check("w8a_xs", xs8, 5'h16);
        check("w8a_ys", ys8, 5'h15);
`endif
        x8 = 8'h3A; y8 = 8'h5F;
        tick();
        check("w8b_halves", {xl8, xr8, yl8, yr8}, 16'h3A5F);
`ifdef KSPLIT_SUM_EN
        check("w8b_xs", xs8, 5'h0D);
        check("w8b_ys", ys8, 5'h14);
`endif
        in_valid8 = 1'b0;
        tick();
        check("w8_op_count", op_count8, 2);

        // Stalled output: three offered, two accepted, delivered in order
        rst = 1'b0; #1 rst = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; x = 32'h11112222; y = 32'hAAAA0001;
        tick();
        check("stall_a_in_ready", in_ready, 1);
        check("stall_a_xl", xl, 16'h1111);
        x = 32'h33334444; y = 32'hBBBB0002;
        tick();
        check("stall_b_in_ready", in_ready, 0);
        check("stall_b_hold_xl", xl, 16'h1111);
        x = 32'h55556666; y = 32'hCCCC0003;
        tick();
        check("stall_c_in_ready", in_ready, 0);
        check("stall_c_hold_yr", yr, 16'h0001);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("stall_deliv_b_xl", xl, 16'h3333);
        check("stall_deliv_b_yr", yr, 16'h0002);
        check("stall_refill_ready", in_ready, 1);
        tick();
        check("stall_empty", out_valid, 0);
        check("stall_op_count", op_count, 2);
        tick();
        check("stall_no_c", out_valid, 0);

        // Reset while two results are held
        out_ready = 1'b0;
        in_valid = 1'b1; x = 32'hDEAD0001; y = 32'hBEEF0002;
        tick();
        x = 32'hDEAD0003;
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_data", {xl, yr}, 0);
        check("mid_rst_op_count", op_count, 0);
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_idle%0d", i), out_valid, 0);
        end
        check("post_rst_op_count", op_count, 0);

        // Random traffic against a queue model
        begin
            int          acc_n;
            int          cyc;
            logic [15:0] exp_cnt;
            pair_t       p;
            acc_n = 0; cyc = 0; exp_cnt = 16'd0;
            while (acc_n < 1000 && cyc < 20000) begin
                in_valid  = ($urandom_range(0, 1) == 1);
                out_ready = ($urandom_range(0, 3) != 0);
                x = $urandom;
                y = $urandom;
                #3;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("rand_spurious", 1, 0);
                    end else begin
                        p = q.pop_front();
                        check("rand_x", {xl, xr}, p.x);
                        check("rand_y", {yl, yr}, p.y);
`ifdef KSPLIT_SUM_EN
                        check("rand_xs", xs, {1'b0, p.x[31:16]} + {1'b0, p.x[15:0]});
                        check("rand_ys", ys, {1'b0, p.y[31:16]} + {1'b0, p.y[15:0]});
`endif
                    end
                    exp_cnt++;
                end
                if (in_valid && in_ready) begin
                    p.x = x; p.y = y;
                    q.push_back(p);
                    acc_n++;
                end
                tick();
                cyc++;
            end
            check("rand_accepted", acc_n, 1000);
            in_valid = 1'b0; out_ready = 1'b1;
            cyc = 0;
            while (q.size() > 0 && cyc < 10) begin
                #3;
                if (out_valid) begin
                    p = q.pop_front();
                    check("drain_x", {xl, xr}, p.x);
                    check("drain_y", {yl, yr}, p.y);
                    exp_cnt++;
                end
                tick();
                cyc++;
            end
            check("rand_left", q.size(), 0);
            check("rand_idle", out_valid, 0);
            check("rand_op_count", op_count, exp_cnt);
        end

        // op_count wrap: 65535 deliveries, then one more
        rst = 1'b0; #1 rst = 1'b1;
        tick();
        out_ready = 1'b1; in_valid = 1'b1; x = 32'h0F0F0F0F; y = 32'hF0F0F0F0;
        repeat (65535) @(posedge clk);
        #1 in_valid = 1'b0;
        tick();
        check("wrap_pre", op_count, 16'hFFFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("wrap_post", op_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/karatsuba_splitter.md
KARATSUBA_SPLITTER -- requirements
Module: karatsuba_splitter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits; legal values are even and >= 4.
REQ-002 SHALL have derived localparam HALF = WIDTH/2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: x/y hold an operand pair.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a pair this cycle.
REQ-007 SHALL have ports x and y, input, WIDTH bits each: operands.
REQ-008 SHALL have port out_valid, output, 1 bit: split outputs hold a result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-010 SHALL have ports xl, xr, yl, yr, output, HALF bits each: upper (l) and lower (r) halves.
REQ-011 SHALL have ports xs and ys, output, HALF+1 bits each: xl+xr and yl+yr. Present only under KSPLIT_SUM_EN.
REQ-012 SHALL have port op_count, output, 16 bits: number of results delivered.

Function
REQ-013 SHALL treat a pair as accepted on a rising clk edge where in_valid and in_ready are both 1.
REQ-014 SHALL treat a result as delivered on a rising clk edge where out_valid and out_ready are both 1.
REQ-015 SHALL split each accepted pair as xl=x[WIDTH-1:HALF], xr=x[HALF-1:0], and likewise for y.
REQ-016 SHALL make an accepted pair visible on the outputs with out_valid=1 one cycle after acceptance when the output stage is empty or is delivering in that cycle.
REQ-017 SHALL hold up to 2 results: an output register plus a skid register.
REQ-018 SHALL drive in_ready = 1 exactly when the skid register is empty; in_ready SHALL be registered, with no combinational path from out_ready.
REQ-019 SHALL capture a pair accepted while the output is stalled (out_valid=1, out_ready=0) into the skid register.
REQ-020 SHALL move the skid contents into the output register on the next delivery.
REQ-021 SHALL deliver results in acceptance order, with no loss and no duplication.
REQ-022 SHALL hold all output data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on simultaneous accept and deliver with the skid empty, load the new pair directly into the output register and keep out_valid at 1.
REQ-024 SHALL compute xs and ys at full HALF+1 width; the carry SHALL never be truncated.
REQ-025 SHALL increment op_count by 1 on each delivery, wrapping from 0xFFFF to 0x0000.
REQ-026 SHALL sustain a throughput of 1 pair per cycle while out_ready is held at 1.

Reset
REQ-027 SHALL, while rst=0, immediately set out_valid=0, in_ready=0, all data outputs=0, op_count=0, and both registers empty.
REQ-028 SHALL drive in_ready=1 on the first rising clk edge after rst is released.
REQ-029 SHALL discard all held results when reset is asserted mid-operation.

Configuration
REQ-030 SHALL use macro KSPLIT_SUM_EN: when defined, ports xs and ys exist and both stages store the sums (registered, same latency as the halves).
REQ-031 SHALL, without KSPLIT_SUM_EN, omit the xs/ys ports and the sum storage; all other behaviour SHALL be identical.

Structure
REQ-032 SHALL take the default width constant and the result-record typedef (xl, xr, yl, yr, and the optional xs, ys) from shared package karatsuba_pkg.
REQ-033 SHALL implement the two-entry storage as sub-module karatsuba_skid, parametrised by payload width and reusable by later Karatsuba stages.

Verification
REQ-034 SHALL cover: WIDTH=32, x=0xABCD1234, y=0x0000FFFF, out_ready=1 -> next cycle xl=0xABCD, xr=0x1234, yl=0x0000, yr=0xFFFF, xs=0x0BE01, ys=0x0FFFF.
REQ-035 SHALL cover: x=y=0xFFFFFFFF -> xs=ys=0x1FFFE (carry kept).
REQ-036 SHALL cover: out_ready=0, 3 pairs offered back-to-back -> 2 accepted, then in_ready=0; release out_ready -> results delivered in order, op_count=2.
REQ-037 SHALL cover: 1000 random pairs with random in_valid/out_ready -> reference-model match, in order, no loss.
REQ-038 SHALL cover: rst pulsed low while 2 results are held -> outputs and op_count 0 immediately, nothing delivered afterwards.
REQ-039 SHALL cover: op_count preloaded by 65535 deliveries, then 1 more -> op_count=0x0000; WIDTH=8 build -> halves 4 bits, sums 5 bits.
